chia_xung_n: RTL and testbench

Multi-channel programmable clock divider. Generates N independent divided square waves (`clko`) and single-cycle tick strobes (`tick`) from one system clock. Each channel's divide ratio can be changed at runtime without glitches, and channels can be phase-aligned. It replaces fixed-ratio single-output dividers and feeds LED blink, display-scan and 1 Hz timebase logic.

---
 rtl/chia_xung_n_pkg.sv | 17 +
 rtl/chia_xung_n_if.sv | 28 ++
 rtl/chia_xung_n_ch.sv | 94 +++++++++
 rtl/chia_xung_n.sv | 64 ++++++
 tb/tb_chia_xung_n.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/chia_xung_n_pkg.sv
// Shared constants and helpers for the chia_xung_n multi-channel clock divider.
package chia_xung_n_pkg;

    // Supported channel-count range.
    localparam int N_MIN        = 1;
    localparam int N_MAX        = 16;

    // Default ratio width and reset ratio (1 Hz from a 100 MHz system clock).
    localparam int W_DEF        = 27;
    localparam int DIV_INIT_DEF = 100000000;

    // Width of the channel-select field; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chia_xung_n_if.sv
// Control/status bundle of the clock divider: enables, phase sync, ratio load
// port, and the divided clock, tick and load-error outputs.
interface chia_xung_n_if #(
    parameter int N  = 4,
    parameter int W  = 27,
    parameter int SW = 2
);
    logic [N-1:0]  en;
    logic          sync;
    logic          div_ld;
    logic [SW-1:0] div_sel;
    logic [W-1:0]  div_val;
    logic [N-1:0]  clko;
    logic [N-1:0]  tick;
    logic          ld_err;

    // Side that drives enables/loads and consumes the divided outputs.
    modport master (
        output en, sync, div_ld, div_sel, div_val,
        input  clko, tick, ld_err
    );

    // The divider itself.
    modport slave (
        input  en, sync, div_ld, div_sel, div_val,
        output clko, tick, ld_err
    );
endinterface

// File: rtl/chia_xung_n_ch.sv
// One divider channel: position counter, active and shadow ratio, pending
// flag, and registered clko/tick. New ratios are staged in the shadow and only
// take effect at a period boundary, on a disabled edge or on a sync edge, so a
// running period always completes with the ratio it started with.
module chia_xung_ch #(
    parameter int W        = 27,
    parameter int DIV_INIT = 100000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic         clko_o,
    output logic         tick_o
);

    logic [W-1:0] cnt_q,  cnt_d;
    logic [W-1:0] div_q,  div_d;
    logic [W-1:0] pdiv_q, pdiv_d;
    logic         pend_q, pend_d;
    logic         clko_q, clko_d;
    logic         tick_q, tick_d;

    // High phase is the rounded-up half, so odd ratios get the longer high phase.
    logic [W:0]   hi_len;
    logic         last;
    logic         hold;
    logic         apply;

    // Next-state logic for counter, ratio staging and outputs.
    always_comb begin
        hi_len = ({1'b0, div_q} + (W+1)'(1)) >> 1;
        last   = (cnt_q == div_q - W'(1));
        hold   = !en_i || sync_i;

        cnt_d  = cnt_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        clko_d = clko_q;
        tick_d = tick_q;
        apply  = 1'b0;

        if (hold) begin
            // Disabled or synced: park at phase 0 and take any staged ratio.
            cnt_d  = '0;
            clko_d = 1'b0;
            tick_d = 1'b0;
            apply  = pend_q;
        end else begin
            cnt_d  = last ? '0 : cnt_q + W'(1);
            clko_d = ({1'b0, cnt_q} < hi_len);
            tick_d = last;
            apply  = last && pend_q;
        end

        if (apply) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
        end

        // A load on the same edge as an apply lands in the shadow and stays
        // pending; the value being applied is the previous shadow contents.
        if (ld_i) begin
            pdiv_d = ld_val_i;
            pend_d = 1'b1;
        end
    end

    // State registers with synchronous reset to the initial ratio.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= W'(DIV_INIT);
            pdiv_q <= W'(DIV_INIT);
            pend_q <= 1'b0;
            clko_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clko_q <= clko_d;
            tick_q <= tick_d;
        end
    end

    assign clko_o = clko_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/chia_xung_n.sv
// Multi-channel programmable clock divider. The top level only decodes the
// load port, rejects illegal loads (zero ratio or out-of-range channel) with a
// one-cycle ld_err pulse, and fans out to N independent channels.
module chia_xung_n
    import chia_xung_n_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int W        = W_DEF,
    parameter  int DIV_INIT = DIV_INIT_DEF,
    localparam int SW       = sel_w(N)
) (
    input logic           clki,
    input logic           rst,
    chia_xung_n_if.slave  bus
);

    logic         rej;
    logic         ld_ok;
    logic [N-1:0] ld_en;
    logic [N-1:0] clko_w;
    logic [N-1:0] tick_w;
    logic         ld_err_q, ld_err_d;

    // Validate the load request and steer it to exactly one channel.
    always_comb begin
        rej      = bus.div_ld && ((bus.div_val == '0) || (int'(bus.div_sel) >= N));
        ld_ok    = bus.div_ld && !rej;
        ld_err_d = rej;
        ld_en    = '0;
        for (int c = 0; c < N; c++) begin
            ld_en[c] = ld_ok && (bus.div_sel == SW'(c));
        end
    end

    // Registered load-error pulse.
    always_ff @(posedge clki) begin
        if (rst) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= ld_err_d;
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_ch
        chia_xung_ch #(
            .W        (W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk_i    (clki),
            .rst_i    (rst),
            .en_i     (bus.en[c]),
            .sync_i   (bus.sync),
            .ld_i     (ld_en[c]),
            .ld_val_i (bus.div_val),
            .clko_o   (clko_w[c]),
            .tick_o   (tick_w[c])
        );
    end

    assign bus.clko   = clko_w;
    assign bus.tick   = tick_w;
    assign bus.ld_err = ld_err_q;

endmodule

// File: tb/tb_chia_xung_n.sv
// Bench for chia_xung_n: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural period model.
module tb_chia_xung_n;
    import chia_xung_n_pkg::*;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int SW  = 2;
    localparam int DI  = 6;

    logic clki = 1'b0;
    logic rst;
    always #5 clki = ~clki;

    chia_xung_n_if #(.N(N), .W(W), .SW(SW)) bus ();

    chia_xung_n #(.N(N), .W(W), .DIV_INIT(DI)) dut (
        .clki (clki),
        .rst  (rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: phase within the current period, active and staged ratio.
    int       m_pos  [N];
    int       m_div  [N];
    int       m_pdiv [N];
    bit       m_pend [N];
    logic [N-1:0] e_clko;
    logic [N-1:0] e_tick;
    logic         e_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic mdl_step();
        bit bad;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_pos[c] = 0; m_div[c] = DI; m_pdiv[c] = DI; m_pend[c] = 0;
            end
            e_clko = '0; e_tick = '0; e_err = 1'b0;
            return;
        end
        bad   = bus.div_ld && (bus.div_val == 0 || int'(bus.div_sel) >= N);
        e_err = bad;
        for (int c = 0; c < N; c++) begin
            if (!bus.en[c] || bus.sync) begin
                e_clko[c] = 1'b0;
                e_tick[c] = 1'b0;
                m_pos[c]  = 0;
                if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
            end else begin
                e_clko[c] = (m_pos[c] < (m_div[c] + 1) / 2);
                e_tick[c] = (m_pos[c] == m_div[c] - 1);
                if (m_pos[c] == m_div[c] - 1) begin
                    m_pos[c] = 0;
                    if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
                end else begin
                    m_pos[c]++;
                end
            end
            if (bus.div_ld && !bad && int'(bus.div_sel) == c) begin
                m_pdiv[c] = int'(bus.div_val);
                m_pend[c] = 1;
            end
        end
    endtask

    // One clock: advance the model, then compare all outputs after the edge.
    task automatic step();
        @(posedge clki);
        mdl_step();
        #1;
        chk("mdl_clko",   32'(bus.clko),   32'(e_clko));
        chk("mdl_tick",   32'(bus.tick),   32'(e_tick));
        chk("mdl_ld_err", 32'(bus.ld_err), 32'(e_err));
    endtask

    // Steps until tick[c] rises; returns the number of edges taken, -1 on timeout.
    task automatic next_tick(input int c, output int n);
        bit found;
        found = 0;
        n = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            step();
            n++;
            if (bus.tick[c]) found = 1;
        end
        if (!found) n = -1;
    endtask

    typedef struct {
        logic [2:0] en;
        logic       ld;
        logic [1:0] sel;
        logic [7:0] val;
        logic       clko;
        logic       tick;
        logic       err;
    } vec_t;

    vec_t tbl [14];
    int   n;

    initial begin
        // ch0: load 4 while disabled, run two periods, then two rejected loads.
        tbl[0]  = '{3'b000, 1'b1, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'b000, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{3'b001, 1'b1, 2'd0, 8'd0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3'b001, 1'b1, 2'd3, 8'd5, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{3'b001, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus.en = '0; bus.sync = 1'b0; bus.div_ld = 1'b0; bus.div_sel = '0; bus.div_val = '0;
        step();
        step();
        chk("rst_clko",   32'(bus.clko),   32'd0);
        chk("rst_tick",   32'(bus.tick),   32'd0);
        chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            bus.en = tbl[i].en; bus.div_ld = tbl[i].ld;
            bus.div_sel = tbl[i].sel; bus.div_val = tbl[i].val;
            step();
            chk($sformatf("tbl%0d_clko0", i), 32'(bus.clko[0]), 32'(tbl[i].clko));
            chk($sformatf("tbl%0d_tick0", i), 32'(bus.tick[0]), 32'(tbl[i].tick));
            chk($sformatf("tbl%0d_ld_err", i), 32'(bus.ld_err), 32'(tbl[i].err));
        end
        bus.div_ld = 1'b0;

        // Mid-period load of 8: current period of 4 finishes first.
        step();
        bus.div_ld = 1'b1; bus.div_sel = 2'd0; bus.div_val = 8'd8;
        step();
        bus.div_ld = 1'b0;
        next_tick(0, n); chk("midld_old_period", 32'(n), 32'd2);
        next_tick(0, n); chk("midld_new_period", 32'(n), 32'd8);

        // Load of 5 on the wrap edge: one more period of 8, then 5.
        for (int k = 0; k < 7; k++) step();
        bus.div_ld = 1'b1; bus.div_sel = 2'd0; bus.div_val = 8'd5;
        step();
        bus.div_ld = 1'b0;
        chk("wrapld_tick", 32'(bus.tick[0]), 32'd1);
        next_tick(0, n); chk("wrapld_still_old", 32'(n), 32'd8);
        next_tick(0, n); chk("wrapld_applied", 32'(n), 32'd5);

        // Channels 1 and 2 at 3 and 7, started staggered, then synced.
        bus.div_ld = 1'b1; bus.div_sel = 2'd1; bus.div_val = 8'd3;
        step();
        bus.div_sel = 2'd2; bus.div_val = 8'd7;
        step();
        bus.div_ld = 1'b0;
        step();
        bus.en = 3'b011;
        step(); step();
        bus.en = 3'b111;
        step(); step(); step();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        chk("sync_clko_low", 32'(bus.clko[2:1]), 32'd0);
        chk("sync_tick_low", 32'(bus.tick[2:1]), 32'd0);
        step();
        chk("sync_clko_align", 32'(bus.clko[2:1]), 32'd3);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            n++;
            if (bus.tick[1] && bus.tick[2]) break;
        end
        chk("sync_tick_coincide", 32'(n), 32'd21);

        // Reset mid-period with a pending load on channel 0.
        bus.en = 3'b001;
        bus.div_ld = 1'b1; bus.div_sel = 2'd0; bus.div_val = 8'd9;
        step();
        bus.div_ld = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_clko", 32'(bus.clko), 32'd0);
        chk("rstmid_tick", 32'(bus.tick), 32'd0);
        next_tick(0, n); chk("rstmid_period_init", 32'(n), 32'(DI));
        next_tick(0, n); chk("rstmid_pend_dropped", 32'(n), 32'(DI));

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rst         = ($urandom_range(299) == 0);
            bus.en      = 3'($urandom);
            bus.sync    = ($urandom_range(19) == 0);
            bus.div_ld  = ($urandom_range(3) == 0);
            bus.div_sel = 2'($urandom_range(3));
            bus.div_val = 8'($urandom_range(12));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
